// File: rtl/tft_timing_gen_ml.sv
// Multi-layer TFT/VGA timing generator: sync/DE, background and overlay-window requests,
// frame-boundary window updates and a latency-matched priority mux to the panel pins.
module tft_timing_gen_ml #(
  parameter int unsigned H_SYNC  = 128,
  parameter int unsigned H_BACK  = 88,
  parameter int unsigned H_DISP  = 800,
  parameter int unsigned H_FRONT = 40,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BACK  = 33,
  parameter int unsigned V_DISP  = 480,
  parameter int unsigned V_FRONT = 10,
  parameter int unsigned CNT_W   = 11,
  parameter int unsigned RGB_W   = 16,
  parameter int unsigned NUM_WIN = 4,
  parameter int unsigned REQ_LAT = 1
) (
  input  logic                       clk_vga,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [2:0]                 cfg_idx,
  input  logic                       cfg_en,
  input  logic [CNT_W-1:0]           cfg_x,
  input  logic [CNT_W-1:0]           cfg_y,
  input  logic [CNT_W-1:0]           cfg_w,
  input  logic [CNT_W-1:0]           cfg_h,
  input  logic [RGB_W-1:0]           bg_data,
  input  logic [NUM_WIN*RGB_W-1:0]   win_data,
  output logic                       tft_req,
  output logic [NUM_WIN-1:0]         win_req,
  output logic [NUM_WIN*CNT_W-1:0]   win_x,
  output logic [NUM_WIN*CNT_W-1:0]   win_y,
  output logic                       frame_start,
  output logic [RGB_W-1:0]           tft_rgb,
  output logic                       tft_hs,
  output logic                       tft_vs,
  output logic                       tft_de,
  output logic                       tft_blank_n,
  output logic                       tft_clk
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int unsigned H_ACT   = H_SYNC + H_BACK;
  localparam int unsigned V_ACT   = V_SYNC + V_BACK;
  // Pipeline word: {win_req, tft_req, vs, hs}
  localparam int unsigned PW      = NUM_WIN + 3;
  localparam logic [PW-1:0] PIPE_RST = {{(NUM_WIN + 1){1'b0}}, 2'b11};

  logic [CNT_W-1:0] hcnt_q, vcnt_q;
  logic             h_last, v_last, wrap;

  assign h_last = (hcnt_q == CNT_W'(H_TOTAL - 1));
  assign v_last = (vcnt_q == CNT_W'(V_TOTAL - 1));
  assign wrap   = h_last && v_last;

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else if (h_last) begin
      hcnt_q <= '0;
      vcnt_q <= v_last ? '0 : vcnt_q + CNT_W'(1);
    end else begin
      hcnt_q <= hcnt_q + CNT_W'(1);
    end
  end

  logic [NUM_WIN-1:0] pend_en_q, shad_en_q;
  logic [CNT_W-1:0]   pend_x_q [NUM_WIN];
  logic [CNT_W-1:0]   pend_y_q [NUM_WIN];
  logic [CNT_W-1:0]   pend_w_q [NUM_WIN];
  logic [CNT_W-1:0]   pend_h_q [NUM_WIN];
  logic [CNT_W-1:0]   shad_x_q [NUM_WIN];
  logic [CNT_W-1:0]   shad_y_q [NUM_WIN];
  logic [CNT_W-1:0]   shad_w_q [NUM_WIN];
  logic [CNT_W-1:0]   shad_h_q [NUM_WIN];

  // Shadow copies old pending on the wrap clock, so a write on that clock waits a frame.
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      pend_en_q <= '0;
      shad_en_q <= '0;
      for (int i = 0; i < NUM_WIN; i++) begin
        pend_x_q[i] <= '0;
        pend_y_q[i] <= '0;
        pend_w_q[i] <= '0;
        pend_h_q[i] <= '0;
        shad_x_q[i] <= '0;
        shad_y_q[i] <= '0;
        shad_w_q[i] <= '0;
        shad_h_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_WIN; i++) begin
        if (cfg_we && (cfg_idx == 3'(i))) begin
          pend_en_q[i] <= cfg_en;
          pend_x_q[i]  <= cfg_x;
          pend_y_q[i]  <= cfg_y;
          pend_w_q[i]  <= cfg_w;
          pend_h_q[i]  <= cfg_h;
        end
        if (wrap) begin
          shad_en_q[i] <= pend_en_q[i];
          shad_x_q[i]  <= pend_x_q[i];
          shad_y_q[i]  <= pend_y_q[i];
          shad_w_q[i]  <= pend_w_q[i];
          shad_h_q[i]  <= pend_h_q[i];
        end
      end
    end
  end

  logic [CNT_W-1:0]   hpos, vpos;
  logic               act;
  logic [NUM_WIN-1:0] win_hit;

  assign hpos = hcnt_q - CNT_W'(H_ACT);
  assign vpos = vcnt_q - CNT_W'(V_ACT);
  assign act  = (hcnt_q >= CNT_W'(H_ACT)) && (hcnt_q < CNT_W'(H_ACT + H_DISP)) &&
                (vcnt_q >= CNT_W'(V_ACT)) && (vcnt_q < CNT_W'(V_ACT + V_DISP));

  // One extra bit on the compares keeps x+w from wrapping past the counter range.
  always_comb begin
    win_hit = '0;
    for (int i = 0; i < NUM_WIN; i++) begin
      win_hit[i] = shad_en_q[i] && act &&
                   ({1'b0, hpos} >= {1'b0, shad_x_q[i]}) &&
                   ({1'b0, hpos} < ({1'b0, shad_x_q[i]} + {1'b0, shad_w_q[i]})) &&
                   ({1'b0, vpos} >= {1'b0, shad_y_q[i]}) &&
                   ({1'b0, vpos} < ({1'b0, shad_y_q[i]} + {1'b0, shad_h_q[i]}));
    end
  end

  logic raw_hs_q, raw_vs_q;

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      tft_req     <= 1'b0;
      win_req     <= '0;
      win_x       <= '0;
      win_y       <= '0;
      frame_start <= 1'b0;
      raw_hs_q    <= 1'b1;
      raw_vs_q    <= 1'b1;
    end else begin
      tft_req     <= act;
      win_req     <= win_hit;
      frame_start <= wrap;
      raw_hs_q    <= (hcnt_q >= CNT_W'(H_SYNC));
      raw_vs_q    <= (vcnt_q >= CNT_W'(V_SYNC));
      for (int i = 0; i < NUM_WIN; i++) begin
        win_x[i*CNT_W +: CNT_W] <= win_hit[i] ? hpos - shad_x_q[i] : '0;
        win_y[i*CNT_W +: CNT_W] <= win_hit[i] ? vpos - shad_y_q[i] : '0;
      end
    end
  end

  logic [PW-1:0] pipe_in, pipe_out;

  assign pipe_in = {win_req, tft_req, raw_vs_q, raw_hs_q};

  if (REQ_LAT == 0) begin : g_no_dly
    assign pipe_out = pipe_in;
  end else begin : g_dly
    logic [PW-1:0] sr_q [REQ_LAT];

    always_ff @(posedge clk_vga) begin
      if (rst) begin
        for (int k = 0; k < REQ_LAT; k++) sr_q[k] <= PIPE_RST;
      end else begin
        sr_q[0] <= pipe_in;
        for (int k = 1; k < REQ_LAT; k++) sr_q[k] <= sr_q[k-1];
      end
    end

    assign pipe_out = sr_q[REQ_LAT-1];
  end

  logic [NUM_WIN-1:0] dly_win_req;
  logic               dly_req;
  logic [RGB_W-1:0]   rgb_mux;

  assign dly_win_req = pipe_out[PW-1:3];
  assign dly_req     = pipe_out[2];

  // Later (higher-index) windows overwrite earlier ones.
  always_comb begin
    rgb_mux = dly_req ? bg_data : '0;
    for (int i = 0; i < NUM_WIN; i++) begin
      if (dly_win_req[i]) rgb_mux = win_data[i*RGB_W +: RGB_W];
    end
  end

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      tft_rgb <= '0;
      tft_hs  <= 1'b1;
      tft_vs  <= 1'b1;
      tft_de  <= 1'b0;
    end else begin
      tft_rgb <= rgb_mux;
      tft_hs  <= pipe_out[0];
      tft_vs  <= pipe_out[1];
      tft_de  <= dly_req;
    end
  end

  assign tft_blank_n = tft_de;
  assign tft_clk     = clk_vga;

endmodule
